// File: rtl/ternary_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ternary_pkg : shared balanced-ternary types, trit codes and helpers   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_POS  = 2'b10;
  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_NEG  = 2'b01;
  localparam trit_t TRIT_ERR  = 2'b11;

  function automatic logic trit_is_err(input trit_t t);
    return (t == TRIT_ERR);
  endfunction

endpackage : ternary_pkg
`default_nettype wire

// File: rtl/or_te_trit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | or_te_trit : combinational trit maximum of one pair plus illegal flag |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module or_te_trit
  import ternary_pkg::*;
(
  input  trit_t a,
  input  trit_t b,
  output trit_t c,
  output logic  err
);

  always_comb begin
    err = trit_is_err(a) | trit_is_err(b);
    // An illegal code on either side wins over any ordering decision.
    if (err) begin
      c = TRIT_ERR;
    end else if ((a == TRIT_POS) || (b == TRIT_POS)) begin
      c = TRIT_POS;
    end else if ((a == TRIT_ZERO) || (b == TRIT_ZERO)) begin
      c = TRIT_ZERO;
    end else begin
      c = TRIT_NEG;
    end
  end

endmodule : or_te_trit
`default_nettype wire

// File: rtl/or_te.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | or_te : registered trit-wise OR (maximum) of two ternary operands     |
// | Option macro: OR_TE_ERR_STICKY_EN (err holds until reset)  Rev 1.0    |
// +----------------------------------------------------------------------+
module or_te
  import ternary_pkg::*;
#(
  parameter int TRITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*TRITS-1:0] a,
  input  logic [2*TRITS-1:0] b,
  output logic [2*TRITS-1:0] c,
  output logic               err
);

  logic [2*TRITS-1:0] w_c;
  logic [TRITS-1:0]   w_err;
  logic [2*TRITS-1:0] r_c;
  logic               r_err;

  for (genvar i = 0; i < TRITS; i++) begin : g_trit
    or_te_trit u_trit (
      .a   (a[2*i+1:2*i]),
      .b   (b[2*i+1:2*i]),
      .c   (w_c[2*i+1:2*i]),
      .err (w_err[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c   <= {TRITS{TRIT_ZERO}};
      r_err <= 1'b0;
    end else begin
      r_c <= w_c;
`ifdef OR_TE_ERR_STICKY_EN
      r_err <= r_err | (|w_err);
`else
      r_err <= |w_err;
`endif
    end
  end

  assign c   = r_c;
  assign err = r_err;

endmodule : or_te
`default_nettype wire

// File: tb/tb_or_te.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_or_te : randomized scoreboard bench for or_te (TRITS = 1 and 3)    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_or_te;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a1 = 2'b10, b1 = 2'b10;
  logic [5:0] a3 = 6'b0, b3 = 6'b0;
  logic [1:0] c1;
  logic [5:0] c3;
  logic       err1, err3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] c1;
    logic       e1;
    logic [5:0] c3;
    logic       e3;
  } exp_t;

  exp_t expq[$];
  logic stick1 = 1'b0, stick3 = 1'b0;

  or_te #(.TRITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .err(err1));
  or_te #(.TRITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .c(c3), .err(err3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Reference model: trits as integers -1/0/+1, result is the arithmetic max.
  function automatic int tval(input logic [1:0] t);
    case (t)
      2'b10:   return 1;
      2'b00:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] tenc(input int v);
    if (v > 0) return 2'b10;
    if (v == 0) return 2'b00;
    return 2'b01;
  endfunction

  task automatic model(input logic [5:0] av, input logic [5:0] bv, input int n,
                       output logic [5:0] cv, output logic ev);
    cv = '0;
    ev = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [1:0] ta, tb;
      ta = av[2*i +: 2];
      tb = bv[2*i +: 2];
      if (ta == 2'b11 || tb == 2'b11) begin
        cv[2*i +: 2] = 2'b11;
        ev = 1'b1;
      end else begin
        cv[2*i +: 2] = tenc((tval(ta) > tval(tb)) ? tval(ta) : tval(tb));
      end
    end
  endtask

  task automatic drive(input logic [1:0] a1v, input logic [1:0] b1v,
                       input logic [5:0] a3v, input logic [5:0] b3v);
    exp_t x;
    logic [5:0] cv;
    logic ev;
    @(negedge clk);
    a1 = a1v; b1 = b1v; a3 = a3v; b3 = b3v;
    model({4'b0, a1v}, {4'b0, b1v}, 1, cv, ev);
    x.c1 = cv[1:0];
`ifdef OR_TE_ERR_STICKY_EN
    stick1 = stick1 | ev;
    x.e1 = stick1;
`else
    x.e1 = ev;
`endif
    model(a3v, b3v, 3, cv, ev);
    x.c3 = cv;
`ifdef OR_TE_ERR_STICKY_EN
    stick3 = stick3 | ev;
    x.e3 = stick3;
`else
    x.e3 = ev;
`endif
    expq.push_back(x);
  endtask

  task automatic drive1(input logic [1:0] av, input logic [1:0] bv);
    drive(av, bv, {3{av}}, {3{bv}});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_c1"}, {4'b0, c1}, 6'b0);
    check({tag, "_e1"}, {5'b0, err1}, 6'b0);
    check({tag, "_c3"}, c3, 6'b0);
    check({tag, "_e3"}, {5'b0, err3}, 6'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    expq.delete();
    stick1 = 1'b0;
    stick3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one result per cycle while out of reset.
  always @(posedge clk) begin
    #1;
    if (rst_n && expq.size() > 0) begin
      exp_t x;
      x = expq.pop_front();
      check("c1", {4'b0, c1}, {4'b0, x.c1});
      check("err1", {5'b0, err1}, {5'b0, x.e1});
      check("c3", c3, x.c3);
      check("err3", {5'b0, err3}, {5'b0, x.e3});
    end
  end

  function automatic logic [1:0] rtrit(input int illegal_pct);
    logic [1:0] t;
    if ($urandom_range(99) < illegal_pct) return 2'b11;
    case ($urandom_range(2))
      0:       t = 2'b10;
      1:       t = 2'b00;
      default: t = 2'b01;
    endcase
    return t;
  endfunction

  initial begin
    logic [1:0] lv[3];
    lv[0] = 2'b10; lv[1] = 2'b00; lv[2] = 2'b01;

    // Reset held with non-zero inputs while the clock runs.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_cleared("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Full legal truth table.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        drive1(lv[i], lv[j]);

    // Illegal input then legal recovery (sticky behaviour via model).
    drive1(2'b11, 2'b10);
    drive1(2'b00, 2'b01);

    // Both illegal, then asynchronous reset.
    drive1(2'b11, 2'b11);
    reset_pulse();

    // Multi-trit directed case.
    drive(2'b10, 2'b01, 6'b100001, 6'b011100);
    drive1(2'b01, 2'b01);

    // Randomized back-to-back traffic with occasional reset.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] ra, rb;
      for (int t = 0; t < 3; t++) begin
        ra[2*t +: 2] = rtrit(8);
        rb[2*t +: 2] = rtrit(8);
      end
      drive(rtrit(8), rtrit(8), ra, rb);
      if (n % 97 == 96) reset_pulse();
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 6'(expq.size()), 6'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_or_te
`default_nettype wire

// File: doc/or_te.md
# or_te

Ternary OR (trit-wise maximum) of two balanced-ternary operands for the ternary RISC-V datapath. The block compares each trit position of `a` and `b`, returns the larger trit on `c`, and flags any illegal trit encoding on `err`. Outputs are registered, with one cycle of latency. The block sits in the ternary ALU logic-operation group, alongside the other trit-wise operators.

## Interface
Parameters:
- `TRITS`, default 1: number of trits per operand. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `a`, input, 2*TRITS: operand A; trit i occupies bits [2i+1:2i].
- `b`, input, 2*TRITS: operand B; same layout as `a`.
- `c`, output, 2*TRITS: registered trit-wise maximum of `a` and `b`.
- `err`, output, 1: registered flag; 1 when any input trit uses the illegal encoding.

## Operation
- Trit encoding (2 bits per trit):
  - 2'b10 = +1
  - 2'b00 = 0
  - 2'b01 = −1
  - 2'b11 = illegal
- Per trit position i, when both input trits are legal, the result is c_i = max(a_i, b_i) with ordering −1 < 0 < +1:
  - any +1 → +1;
  - else any 0 → 0;
  - else −1.
- When either a_i or b_i is 2'b11, c_i = 2'b11 (the illegal code propagates) and that position raises its error.
- `err` = OR of all per-position error indications.
- The operation is commutative: swapping `a` and `b` gives an identical `c`.
- Inputs `a` and `b` are X or Z (undriven): the result is don't-care, but it must not latch X into `err` after the next legal sample. This is a verification note only.

## Timing
- `a` and `b` are sampled on every rising edge of `clk`. The result appears on `c` and `err` after that edge; latency is exactly 1 cycle.
- Throughput is one operation per cycle, with no handshake.
- Reset: while `rst_n` = 0, `c` = all 2'b00 (all trits zero) and `err` = 0, asynchronously, regardless of `clk`.
- Deassertion of `rst_n` takes effect at the next rising edge of `clk`. The first sampled result appears one cycle after the first edge with `rst_n` = 1.
- Reset asserted mid-stream: outputs clear immediately, and in-flight results are discarded.

## Configuration
- `OR_TE_ERR_STICKY_EN`:
  - Defined: once `err` is set, it stays at 1 until `rst_n` is asserted, even if later inputs are legal. `c` still updates every cycle.
  - Not defined: `err` reflects only the previous cycle's inputs.

## Structure
- Shared package `ternary_pkg` holds:
  - `trit_t` (2-bit logic);
  - constants `TRIT_POS` = 2'b10, `TRIT_ZERO` = 2'b00, `TRIT_NEG` = 2'b01, `TRIT_ERR` = 2'b11;
  - function `trit_is_err`.
- Sub-module `or_te_trit` is purely combinational. It takes one trit pair and produces one result trit plus one error bit, and is instantiated TRITS times with a generate loop.
- The top level holds the output registers, the error reduction and the sticky-error option.

## Test plan
Each scenario uses TRITS = 1 unless stated; "after 1 cycle" means after the next rising edge.
- Reset: hold `rst_n` = 0 with a = 2'b10, b = 2'b10 and toggle `clk` → c = 2'b00, err = 0 throughout.
- Full legal truth table: apply all 9 legal pairs → after 1 cycle each, c = max of the pair. Examples:
  - (+1, −1) → 2'b10;
  - (0, −1) → 2'b00;
  - (−1, −1) → 2'b01;
  - (0, 0) → 2'b00.
- Illegal input: a = 2'b11, b = 2'b10 → after 1 cycle c = 2'b11, err = 1. Then apply a = 2'b00, b = 2'b01 → after 1 cycle:
  - c = 2'b00;
  - err = 0 without `OR_TE_ERR_STICKY_EN`;
  - err = 1 with `OR_TE_ERR_STICKY_EN`.
- Both inputs illegal: a = b = 2'b11 → c = 2'b11, err = 1; then pulse `rst_n` low → c = 2'b00, err = 0 immediately, without waiting for a clock edge.
- Multi-trit (TRITS = 3): a = {10,00,01}, b = {01,11,00} → c = {10,11,00}, err = 1.
- Back-to-back operands changing every cycle → each result appears exactly 1 cycle later, with no dropped or duplicated results.
